cp_alloc_ctrl: RTL and testbench
================================

// Module: cp_alloc_ctrl
// PURPOSE
//  Allocates, releases and recovers the RAT's rename checkpoints.
//  Checkpoints form a circular pool of CP_SIZE slots.
//  Rename requests one slot per branch uop, in bundle order; commit frees the oldest slots.
//  A misprediction truncates the pool back to the mispredicted branch's slot.
//  Sits between decode/rename control and the mapping table: produces check/check_idx and rename stall.
// PARAMETERS
//  CP_SIZE       8  checkpoint slots; power of two, >=2 (`RAT_CP_SIZE)
//  ALLOC_WIDTH   4  rename slots per cycle (`RENAME_WIDTH)
//  RETIRE_WIDTH  4  commit slots per cycle (`COMMIT_WIDTH)
//  RECOVER_LAT   2  extra cycles allocation stays blocked after recover; 0..7
// PORTS
//  clock         in   1                 clock
//  reset         in   1                 reset, synchronous, active-high
//  alloc_req     in   ALLOC_WIDTH       slot i holds a valid branch needing a checkpoint
//  alloc_grant   out  ALLOC_WIDTH       slot i's checkpoint allocated this cycle
//  alloc_idx     out  ALLOC_WIDTH*IDX   slot index given to slot i (IDX=$clog2(CP_SIZE))
//  alloc_stall   out  1                 requests pending but not granted; rename must hold bundle
//  retire_valid  in   RETIRE_WIDTH      committing branch in commit slot j frees oldest slot
//  recover       in   1                 misprediction recovery pulse
//  recover_idx   in   IDX               checkpoint index of the mispredicted branch
//  cp_head       out  IDX               index of oldest live checkpoint
//  cp_count      out  IDX+1             live checkpoints, 0..CP_SIZE
//  cp_full       out  1                 cp_count==CP_SIZE
//  cp_empty      out  1                 cp_count==0
//  err_underflow out  1                 sticky: retire while pool empty
// BEHAVIOUR
//  - Reset: head=0, count=0, state=RUN, hold_cnt=0, err_underflow=0, cp_empty=1, cp_full=0.
//    Reset also forces grant=0 and stall=0 that cycle.
//  - FSM RUN/HOLD:
//    - recover in any state -> HOLD with hold_cnt=RECOVER_LAT.
//    - HOLD decrements hold_cnt each cycle; goes to RUN when it reaches 0.
//    - RECOVER_LAT=0: recover blocks allocation in its own cycle only.
//  - Step 1, retire: nret = popcount(retire_valid).
//    - head_r = head+nret mod CP_SIZE; count_r = count-nret.
//    - If nret>count, clamp to count and set err_underflow.
//  - Step 2, recover: count_n = ((recover_idx-head_r) mod CP_SIZE)+1.
//    - Head is unchanged and the mispredicted branch's slot is kept.
//    - No grants this cycle.
//  - Step 3, allocate: RUN, no recover, nreq=popcount(alloc_req).
//    - If nreq <= CP_SIZE-count_r: grant all requests.
//    - alloc_idx[i] = head_r+count_r+(requesting slots before i) mod CP_SIZE.
//    - count_n = count_r+nreq.
//    - Otherwise: grant none, alloc_stall=1 (all-or-nothing, keeps bundle atomic).
//  - In HOLD or on a recover cycle: grant=0, alloc_stall=|alloc_req.
//  - Retire frees are visible to allocation in the same cycle (comb path retire->grant).
//  - alloc_grant, alloc_idx, alloc_stall are combinational.
//    cp_head, cp_count, cp_full, cp_empty, err_underflow are registered.
//  - Indices wrap mod CP_SIZE using IDX-bit natural overflow; count is never above CP_SIZE.
//  - Retire and recover in the same cycle: retire applies first, then recover truncates from head_r.
// CONFIGURATION
//  CP_ALLOC_PERF_EN defined:
//    - adds outputs perf_stall_cycles[31:0] (cycles with alloc_stall=1)
//      and perf_recovers[15:0] (recover pulses).
//    - Both saturate and are cleared on reset.
//  CP_ALLOC_PERF_EN undefined: these ports and counters do not exist.
// STRUCTURE
//  Shared package micro_op: cp_index_t, RAT_CP_SIZE, RENAME_WIDTH, COMMIT_WIDTH,
//  and a typedef enum logic {CP_RUN, CP_HOLD} cp_state_t.
//  Sub-module cp_prefix_cnt: ALLOC_WIDTH-bit prefix popcount producing per-slot offsets and total.
// TESTING
//  1. Reset, alloc_req=4'b0101 -> grant=0101, idx[0]=0, idx[2]=1; next cycle count=2.
//  2. count=7 (CP_SIZE 8), alloc_req=4'b0011 -> grant=0, stall=1, count stays 7.
//     Same with retire_valid=1 -> grant=0011, count=8, full=1.
//  3. head=6, count=2, alloc_req=4'b1111, retire 2 -> idx=0,1,2,3 (wrap), head=0, count=4.
//  4. head=2, count=5, recover, recover_idx=4 -> count=3.
//     alloc_req held high: grant=0 for 1+RECOVER_LAT=3 cycles, granted on 4th.
//  5. head=7, count=3, retire 1 + recover, recover_idx=1 -> head=0, count=2.
//  6. Empty pool, retire_valid=1 -> err_underflow=1 sticky, count stays 0; reset clears.
//     With CP_ALLOC_PERF_EN: 5 stalled cycles -> perf_stall_cycles=5.

Source files
------------

// File: rtl/micro_op.sv
// Shared micro-op / rename definitions used by the checkpoint allocator.
//   RAT_CP_SIZE   : number of RAT rename checkpoints (power of two, >= 2)
//   RENAME_WIDTH  : rename slots per cycle
//   COMMIT_WIDTH  : commit slots per cycle
//   cp_index_t    : checkpoint index type
//   cp_state_t    : allocator run/hold state
package micro_op;

  localparam int unsigned RAT_CP_SIZE  = 8;
  localparam int unsigned RENAME_WIDTH = 4;
  localparam int unsigned COMMIT_WIDTH = 4;
  localparam int unsigned CP_IDX_W     = $clog2(RAT_CP_SIZE);

  typedef logic [CP_IDX_W-1:0] cp_index_t;

  typedef enum logic {
    CP_RUN,
    CP_HOLD
  } cp_state_t;

endpackage

// File: rtl/cp_prefix_cnt.sv
// Prefix popcount over a request vector.
//   bits_i  : input vector
//   offs_o  : offs_o[i] = number of set bits in bits_i[i-1:0]
//   total_o : number of set bits in bits_i
module cp_prefix_cnt #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]            bits_i,
  output logic [WIDTH-1:0][CNT_W-1:0] offs_o,
  output logic [CNT_W-1:0]            total_o
);

  logic [CNT_W-1:0] acc;

  always_comb begin
    acc    = '0;
    offs_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      offs_o[i] = acc;
      acc       = acc + CNT_W'(bits_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/cp_alloc_ctrl.sv
// Rename checkpoint allocator: circular pool of CP_SIZE checkpoints.
// Rename allocates one checkpoint per branch uop (all-or-nothing per bundle),
// commit frees the oldest, and a misprediction truncates the pool back to the
// mispredicted branch's checkpoint (which is kept).
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   alloc_req_i/grant_o   : per rename slot request / grant (grant is combinational)
//   alloc_idx_o           : checkpoint index for each rename slot, IDX bits per slot
//   alloc_stall_o         : requests present but not granted; rename holds its bundle
//   retire_valid_i        : per commit slot, frees the oldest checkpoint
//   recover_i/recover_idx_i : misprediction pulse and the branch's checkpoint index
//   cp_head_o, cp_count_o : oldest live checkpoint, number of live checkpoints
//   cp_full_o, cp_empty_o : registered pool status
//   err_underflow_o       : sticky, retire seen with more frees than live checkpoints
// Optional: define CP_ALLOC_PERF_EN to add saturating perf_stall_cycles_o and
// perf_recovers_o counters.
module cp_alloc_ctrl
  import micro_op::*;
#(
  parameter  int unsigned CP_SIZE      = RAT_CP_SIZE,
  parameter  int unsigned ALLOC_WIDTH  = RENAME_WIDTH,
  parameter  int unsigned RETIRE_WIDTH = COMMIT_WIDTH,
  parameter  int unsigned RECOVER_LAT  = 2,
  localparam int unsigned IDX          = $clog2(CP_SIZE),
  localparam int unsigned CW           = IDX + 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [ALLOC_WIDTH-1:0]     alloc_req_i,
  output logic [ALLOC_WIDTH-1:0]     alloc_grant_o,
  output logic [ALLOC_WIDTH*IDX-1:0] alloc_idx_o,
  output logic                       alloc_stall_o,
  input  logic [RETIRE_WIDTH-1:0]    retire_valid_i,
  input  logic                       recover_i,
  input  logic [IDX-1:0]             recover_idx_i,
  output logic [IDX-1:0]             cp_head_o,
  output logic [CW-1:0]              cp_count_o,
  output logic                       cp_full_o,
  output logic                       cp_empty_o,
`ifdef CP_ALLOC_PERF_EN
  output logic [31:0]                perf_stall_cycles_o,
  output logic [15:0]                perf_recovers_o,
`endif
  output logic                       err_underflow_o
);

  localparam int unsigned AW = $clog2(ALLOC_WIDTH + 1);
  localparam int unsigned RW = $clog2(RETIRE_WIDTH + 1);

  // State
  cp_state_t      state_q;
  logic [2:0]     hold_cnt_q;
  logic [IDX-1:0] head_q, head_d;
  logic [CW-1:0]  count_q, count_d;
  logic           full_q, empty_q;
  logic           err_q, err_d;

  // Allocation slot offsets
  logic [ALLOC_WIDTH-1:0][AW-1:0] req_offs;
  logic [AW-1:0]                  nreq;

  cp_prefix_cnt #(
    .WIDTH (ALLOC_WIDTH),
    .CNT_W (AW)
  ) u_prefix (
    .bits_i  (alloc_req_i),
    .offs_o  (req_offs),
    .total_o (nreq)
  );

  // Retire step
  logic [RW-1:0]  nret;
  logic           underflow;
  logic [CW-1:0]  nret_eff;
  logic [IDX-1:0] head_r;
  logic [CW-1:0]  count_r;
  logic [IDX-1:0] tail_r;

  always_comb begin
    nret = '0;
    for (int j = 0; j < RETIRE_WIDTH; j++) begin
      nret = nret + RW'(retire_valid_i[j]);
    end
    underflow = int'(nret) > int'(count_q);
    nret_eff  = underflow ? count_q : CW'(nret);
    // nret_eff == CP_SIZE leaves the low IDX bits zero: a full lap keeps head in place.
    head_r    = head_q + nret_eff[IDX-1:0];
    count_r   = count_q - nret_eff;
    tail_r    = head_r + count_r[IDX-1:0];
  end

  // Recover and allocate steps
  logic [IDX-1:0] rec_dist;
  logic [CW-1:0]  rec_count;
  logic [CW-1:0]  free_r;
  logic           alloc_ok;
  logic           fits;
  logic           do_alloc;

  always_comb begin
    rec_dist  = recover_idx_i - head_r;
    rec_count = CW'(rec_dist) + CW'(1);
    free_r    = CW'(CP_SIZE) - count_r;
    fits      = int'(nreq) <= int'(free_r);
    alloc_ok  = (state_q == CP_RUN) && !recover_i && !reset;
    do_alloc  = alloc_ok && fits;

    alloc_grant_o = do_alloc ? alloc_req_i : '0;
    alloc_stall_o = !reset && (|alloc_req_i) && !do_alloc;
    alloc_idx_o   = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_idx_o[i*IDX +: IDX] = tail_r + IDX'(req_offs[i]);
    end

    head_d = head_r;
    err_d  = err_q | underflow;
    if (recover_i) begin
      count_d = rec_count;
    end else if (do_alloc) begin
      count_d = count_r + CW'(nreq);
    end else begin
      count_d = count_r;
    end
  end

  // Run/hold FSM: recover blocks allocation for its own cycle plus RECOVER_LAT cycles.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= CP_RUN;
      hold_cnt_q <= '0;
    end else if (recover_i) begin
      if (RECOVER_LAT == 0) begin
        state_q    <= CP_RUN;
        hold_cnt_q <= '0;
      end else begin
        state_q    <= CP_HOLD;
        hold_cnt_q <= 3'(RECOVER_LAT);
      end
    end else begin
      unique case (state_q)
        CP_RUN: begin
          state_q    <= CP_RUN;
          hold_cnt_q <= '0;
        end
        CP_HOLD: begin
          hold_cnt_q <= hold_cnt_q - 3'd1;
          if (hold_cnt_q <= 3'd1) begin
            state_q <= CP_RUN;
          end
        end
        default: begin
          state_q    <= CP_RUN;
          hold_cnt_q <= '0;
        end
      endcase
    end
  end

  // Pool pointers and status
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      full_q  <= (count_d == CW'(CP_SIZE));
      empty_q <= (count_d == '0);
      err_q   <= err_d;
    end
  end

  assign cp_head_o       = head_q;
  assign cp_count_o      = count_q;
  assign cp_full_o       = full_q;
  assign cp_empty_o      = empty_q;
  assign err_underflow_o = err_q;

`ifdef CP_ALLOC_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_rec_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_rec_q   <= '0;
    end else begin
      if (alloc_stall_o && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if (recover_i && (perf_rec_q != '1)) begin
        perf_rec_q <= perf_rec_q + 16'd1;
      end
    end
  end

  assign perf_stall_cycles_o = perf_stall_q;
  assign perf_recovers_o     = perf_rec_q;
`endif

endmodule

// File: tb/tb_cp_alloc_ctrl.sv
// Directed self-checking bench for cp_alloc_ctrl (CP_SIZE=8, widths 4, RECOVER_LAT=2).
module tb_cp_alloc_ctrl;

  logic        clock;
  logic        reset;
  logic [3:0]  alloc_req;
  logic [3:0]  alloc_grant;
  logic [11:0] alloc_idx;
  logic        alloc_stall;
  logic [3:0]  retire_valid;
  logic        recover;
  logic [2:0]  recover_idx;
  logic [2:0]  cp_head;
  logic [3:0]  cp_count;
  logic        cp_full;
  logic        cp_empty;
  logic        err_underflow;
`ifdef CP_ALLOC_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_recovers;
`endif

  int errors = 0;
  int checks = 0;

  cp_alloc_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .alloc_req_i     (alloc_req),
    .alloc_grant_o   (alloc_grant),
    .alloc_idx_o     (alloc_idx),
    .alloc_stall_o   (alloc_stall),
    .retire_valid_i  (retire_valid),
    .recover_i       (recover),
    .recover_idx_i   (recover_idx),
    .cp_head_o       (cp_head),
    .cp_count_o      (cp_count),
    .cp_full_o       (cp_full),
    .cp_empty_o      (cp_empty),
`ifdef CP_ALLOC_PERF_EN
    .perf_stall_cycles_o (perf_stall_cycles),
    .perf_recovers_o     (perf_recovers),
`endif
    .err_underflow_o (err_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_req    = '0;
    retire_valid = '0;
    recover      = 1'b0;
    recover_idx  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // One cycle of allocate/retire stimulus, inputs returned to idle afterwards.
  task automatic cyc(input logic [3:0] req, input logic [3:0] ret);
    alloc_req    = req;
    retire_valid = ret;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset     = 1'b1;
    alloc_req = 4'b1111;
    #1;
    checks++;
    if (alloc_grant !== 4'b0000) begin
      errors++; $display("FAIL reset_grant: got %b expected 0000", alloc_grant);
    end
    checks++;
    if (alloc_stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", alloc_stall);
    end
    tick();
    checks++;
    if ({cp_head, cp_count, cp_full, cp_empty, err_underflow} !== {3'd0, 4'd0, 1'b0, 1'b1, 1'b0})
    begin
      errors++;
      $display("FAIL reset_state: head=%0d count=%0d full=%b empty=%b err=%b expected 0 0 0 1 0",
               cp_head, cp_count, cp_full, cp_empty, err_underflow);
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_alloc_basic();
    do_reset();
    alloc_req = 4'b0101;
    #1;
    checks++;
    if (alloc_grant !== 4'b0101) begin
      errors++; $display("FAIL basic_grant: got %b expected 0101", alloc_grant);
    end
    checks++;
    if ({alloc_idx[8:6], alloc_idx[2:0]} !== {3'd1, 3'd0}) begin
      errors++;
      $display("FAIL basic_idx: idx2=%0d idx0=%0d expected 1 0", alloc_idx[8:6], alloc_idx[2:0]);
    end
    checks++;
    if (alloc_stall !== 1'b0) begin
      errors++; $display("FAIL basic_stall: got %b expected 0", alloc_stall);
    end
    tick();
    idle_inputs();
    checks++;
    if ({cp_count, cp_empty} !== {4'd2, 1'b0}) begin
      errors++; $display("FAIL basic_count: count=%0d empty=%b expected 2 0", cp_count, cp_empty);
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    cyc(4'b1111, 4'b0000);
    cyc(4'b0111, 4'b0000);
    alloc_req = 4'b0011;
    #1;
    checks++;
    if ({alloc_grant, alloc_stall} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL full_stall: grant=%b stall=%b expected 0000 1", alloc_grant, alloc_stall);
    end
    tick();
    checks++;
    if (cp_count !== 4'd7) begin
      errors++; $display("FAIL full_hold_count: got %0d expected 7", cp_count);
    end
    // Same bundle with one retire: the freed slot is usable in the same cycle.
    retire_valid = 4'b0001;
    #1;
    checks++;
    if ({alloc_grant, alloc_stall} !== {4'b0011, 1'b0}) begin
      errors++;
      $display("FAIL retire_unblock: grant=%b stall=%b expected 0011 0", alloc_grant, alloc_stall);
    end
    checks++;
    if (alloc_idx[5:0] !== {3'd0, 3'd7}) begin
      errors++;
      $display("FAIL retire_unblock_idx: idx1=%0d idx0=%0d expected 0 7",
               alloc_idx[5:3], alloc_idx[2:0]);
    end
    tick();
    idle_inputs();
    checks++;
    if ({cp_count, cp_full, cp_head} !== {4'd8, 1'b1, 3'd1}) begin
      errors++;
      $display("FAIL full_state: count=%0d full=%b head=%0d expected 8 1 1",
               cp_count, cp_full, cp_head);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc(4'b1111, 4'b0000);
    cyc(4'b1111, 4'b0000);
    cyc(4'b0000, 4'b1111);
    cyc(4'b0000, 4'b0011);
    checks++;
    if ({cp_head, cp_count} !== {3'd6, 4'd2}) begin
      errors++; $display("FAIL wrap_setup: head=%0d count=%0d expected 6 2", cp_head, cp_count);
    end
    alloc_req    = 4'b1111;
    retire_valid = 4'b0011;
    #1;
    checks++;
    if ({alloc_grant, alloc_idx} !== {4'b1111, 3'd3, 3'd2, 3'd1, 3'd0}) begin
      errors++;
      $display("FAIL wrap_idx: grant=%b idx=%h expected 1111 %h", alloc_grant, alloc_idx,
               {3'd3, 3'd2, 3'd1, 3'd0});
    end
    tick();
    idle_inputs();
    checks++;
    if ({cp_head, cp_count} !== {3'd0, 4'd4}) begin
      errors++; $display("FAIL wrap_state: head=%0d count=%0d expected 0 4", cp_head, cp_count);
    end
  endtask

  task automatic test_recover_hold();
    do_reset();
    cyc(4'b1111, 4'b0000);
    cyc(4'b0111, 4'b0000);
    cyc(4'b0000, 4'b0011);
    alloc_req   = 4'b1111;
    recover     = 1'b1;
    recover_idx = 3'd4;
    #1;
    checks++;
    if ({alloc_grant, alloc_stall} !== {4'b0000, 1'b1}) begin
      errors++;
      $display("FAIL recover_cycle: grant=%b stall=%b expected 0000 1", alloc_grant, alloc_stall);
    end
    tick();
    recover = 1'b0;
    checks++;
    if ({cp_head, cp_count} !== {3'd2, 4'd3}) begin
      errors++;
      $display("FAIL recover_count: head=%0d count=%0d expected 2 3", cp_head, cp_count);
    end
    for (int k = 1; k <= 2; k++) begin
      #1;
      checks++;
      if ({alloc_grant, alloc_stall} !== {4'b0000, 1'b1}) begin
        errors++;
        $display("FAIL hold_cycle%0d: grant=%b stall=%b expected 0000 1",
                 k, alloc_grant, alloc_stall);
      end
      tick();
    end
    #1;
    checks++;
    if ({alloc_grant, alloc_stall, alloc_idx} !== {4'b1111, 1'b0, 3'd0, 3'd7, 3'd6, 3'd5}) begin
      errors++;
      $display("FAIL hold_release: grant=%b stall=%b idx=%h expected 1111 0 %h",
               alloc_grant, alloc_stall, alloc_idx, {3'd0, 3'd7, 3'd6, 3'd5});
    end
    tick();
    idle_inputs();
    checks++;
    if (cp_count !== 4'd7) begin
      errors++; $display("FAIL hold_release_count: got %0d expected 7", cp_count);
    end
  endtask

  task automatic test_retire_recover();
    do_reset();
    cyc(4'b1111, 4'b0000);
    cyc(4'b1111, 4'b0000);
    cyc(4'b0000, 4'b1111);
    cyc(4'b0000, 4'b0111);
    cyc(4'b0011, 4'b0000);
    checks++;
    if ({cp_head, cp_count} !== {3'd7, 4'd3}) begin
      errors++; $display("FAIL rr_setup: head=%0d count=%0d expected 7 3", cp_head, cp_count);
    end
    retire_valid = 4'b0001;
    recover      = 1'b1;
    recover_idx  = 3'd1;
    tick();
    idle_inputs();
    checks++;
    if ({cp_head, cp_count} !== {3'd0, 4'd2}) begin
      errors++; $display("FAIL rr_state: head=%0d count=%0d expected 0 2", cp_head, cp_count);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    retire_valid = 4'b0001;
    tick();
    idle_inputs();
    checks++;
    if ({err_underflow, cp_count, cp_empty} !== {1'b1, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL underflow_set: err=%b count=%0d empty=%b expected 1 0 1",
               err_underflow, cp_count, cp_empty);
    end
    tick();
    checks++;
    if (err_underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_sticky: got %b expected 1", err_underflow);
    end
    // Partial clamp: one live checkpoint, three retires.
    do_reset();
    cyc(4'b0001, 4'b0000);
    cyc(4'b0000, 4'b0111);
    checks++;
    if ({err_underflow, cp_count, cp_head} !== {1'b1, 4'd0, 3'd1}) begin
      errors++;
      $display("FAIL underflow_clamp: err=%b count=%0d head=%0d expected 1 0 1",
               err_underflow, cp_count, cp_head);
    end
    do_reset();
    checks++;
    if (err_underflow !== 1'b0) begin
      errors++; $display("FAIL underflow_clear: got %b expected 0", err_underflow);
    end
  endtask

`ifdef CP_ALLOC_PERF_EN
  task automatic test_perf();
    do_reset();
    cyc(4'b1111, 4'b0000);
    cyc(4'b1111, 4'b0000);
    alloc_req = 4'b0001;
    for (int k = 0; k < 5; k++) tick();
    idle_inputs();
    checks++;
    if (perf_stall_cycles !== 32'd5) begin
      errors++; $display("FAIL perf_stall: got %0d expected 5", perf_stall_cycles);
    end
    recover     = 1'b1;
    recover_idx = 3'd2;
    tick();
    idle_inputs();
    checks++;
    if (perf_recovers !== 16'd1) begin
      errors++; $display("FAIL perf_recovers: got %0d expected 1", perf_recovers);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_alloc_basic();
    test_full_stall();
    test_wrap();
    test_recover_hold();
    test_retire_recover();
    test_underflow();
`ifdef CP_ALLOC_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
